// File: rtl/mem_bus_arbiter.sv
// Two-requester memory port arbiter: round-robin grant, registered strobes,
// per-access timeout so a missing mem_ready cannot hang the bus.
module mem_bus_arbiter #(
  parameter int unsigned M       = 16,
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         we0,
  input  logic [N-1:0] addr0,
  input  logic [M-1:0] wdata0,
  output logic         ack0,
  output logic [M-1:0] rdata0,
  input  logic         req1,
  input  logic         we1,
  input  logic [N-1:0] addr1,
  input  logic [M-1:0] wdata1,
  output logic         ack1,
  output logic [M-1:0] rdata1,
  output logic         err,
  output logic [N-1:0] mem_addr,
  output logic [M-1:0] mem_wdata,
  output logic         mem_re,
  output logic         mem_we,
  input  logic [M-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic         owner
);

  // Counter holds 0..TIMEOUT-1; the last value is the final permitted ACCESS cycle.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          weLat;

  logic          anyReq;
  logic          grantSel;
  logic          grantWe;
  logic [N-1:0]  grantAddr;
  logic [M-1:0]  grantWdata;

  // Round-robin pick: on a tie the requester that is not the current owner wins.
  always_comb begin
    anyReq   = req0 | req1;
    grantSel = owner;
    if (req0 && req1) begin
      grantSel = ~owner;
    end else if (req0) begin
      grantSel = 1'b0;
    end else if (req1) begin
      grantSel = 1'b1;
    end
    grantWe    = grantSel ? we1    : we0;
    grantAddr  = grantSel ? addr1  : addr0;
    grantWdata = grantSel ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      weLat     <= 1'b0;
      owner     <= 1'b1;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err       <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner     <= grantSel;
            weLat     <= grantWe;
            mem_addr  <= grantAddr;
            mem_wdata <= grantWdata;
            mem_re    <= ~grantWe;
            mem_we    <= grantWe;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end

        ACCESS: begin
          if (mem_ready) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            err    <= 1'b0;
            state  <= DONE;
            if (owner) begin
              ack1 <= 1'b1;
              if (!weLat) rdata1 <= mem_rdata;
            end else begin
              ack0 <= 1'b1;
              if (!weLat) rdata0 <= mem_rdata;
            end
          end else if (cnt == CntLast) begin
            // Abort: complete the handshake with an error and zeroed read data.
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            err    <= 1'b1;
            state  <= DONE;
            if (owner) begin
              ack1 <= 1'b1;
              if (!weLat) rdata1 <= '0;
            end else begin
              ack0 <= 1'b1;
              if (!weLat) rdata0 <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Structural invariants of the handshake.
  assert property (@(posedge clk) disable iff (!rst) !(mem_re && mem_we));
  assert property (@(posedge clk) disable iff (!rst) !(ack0 && ack1));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: drivers push expected transactions,
// a monitor checks bus cycles and acks against them.
module tb_mem_bus_arbiter;

  localparam int unsigned M  = 16;
  localparam int unsigned N  = 32;
  localparam int unsigned TO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [N-1:0] addr0 = '0, addr1 = '0;
  logic [M-1:0] wdata0 = '0, wdata1 = '0;
  logic         ack0, ack1, err, mem_re, mem_we, owner;
  logic [M-1:0] rdata0, rdata1, mem_wdata;
  logic [N-1:0] mem_addr;
  logic [M-1:0] mem_rdata = 16'hDEAD;
  logic         mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.M(M), .N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  typedef struct {
    logic        who;
    logic        we;
    logic [31:0] addr;
    logic [15:0] wdata;
    int          nAcc;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  logic [15:0] shadow [2] = '{16'h0, 16'h0};
  int   strobeCnt = 0;
  int   waitStates = 0;
  bit   stuck = 1'b0;
  int   memCnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic void push(logic who, logic we, logic [31:0] addr, logic [15:0] wd,
                               int nAcc, logic e, logic [15:0] rd);
    exp_t x;
    x.who = who; x.we = we; x.addr = addr; x.wdata = wd;
    x.nAcc = nAcc; x.err = e; x.rdata = rd;
    expQ.push_back(x);
  endfunction

  // Memory model: ready after waitStates extra cycles, data = addr ^ 16'h6EEF.
  always @(negedge clk) begin
    if (!rst || !(mem_re || mem_we)) begin
      memCnt    = 0;
      mem_ready = 1'b0;
      mem_rdata = 16'hDEAD;
    end else begin
      memCnt++;
      mem_ready = !stuck && (memCnt == waitStates + 1);
      mem_rdata = mem_ready ? (mem_addr[15:0] ^ 16'h6EEF) : 16'hDEAD;
    end
  end

  // Monitor: checks each strobe cycle and each ack against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      strobeCnt = 0;
    end else begin
      if (mem_re || mem_we) begin
        if (expQ.size() == 0) begin
          chk("unexpected_access", 32'(1), 32'(0));
        end else begin
          e = expQ[0];
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_re", 32'(mem_re), 32'(!e.we));
          chk("mem_we", 32'(mem_we), 32'(e.we));
          if (e.we) chk("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
          chk("owner_busy", 32'(owner), 32'(e.who));
          strobeCnt++;
        end
      end
      if (ack0 || ack1) begin
        chk("ack_overlap", 32'(ack0 & ack1), 32'(0));
        if (expQ.size() == 0) begin
          chk("unexpected_ack", 32'(1), 32'(0));
        end else begin
          e = expQ.pop_front();
          chk("ack_who", 32'(ack1), 32'(e.who));
          chk("owner", 32'(owner), 32'(e.who));
          chk("access_cycles", 32'(strobeCnt), 32'(e.nAcc));
          chk("err", 32'(err), 32'(e.err));
          if (!e.we) shadow[e.who] = e.rdata;
          chk("rdata0", 32'(rdata0), 32'(shadow[0]));
          chk("rdata1", 32'(rdata1), 32'(shadow[1]));
        end
        strobeCnt = 0;
      end
    end
  end

  task automatic setReq(input bit who, input bit v, input bit we,
                        input logic [31:0] addr, input logic [15:0] wd);
    if (who) begin
      req1 = v; we1 = we; addr1 = addr; wdata1 = wd;
    end else begin
      req0 = v; we0 = we; addr0 = addr; wdata0 = wd;
    end
  endtask

  task automatic waitAck(input bit who, output int cyc);
    bit got = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (who ? ack1 : ack0) begin
        got = 1'b1;
        cyc = i;
        break;
      end
    end
    if (!got) chk("ack_wait_expired", 32'(0), 32'(1));
  endtask

  task automatic runReq(input bit who, input bit we, input logic [31:0] addr,
                        input logic [15:0] wd, input int n, output int cyc);
    setReq(who, 1'b1, we, addr, wd);
    for (int i = 0; i < n; i++) waitAck(who, cyc);
    setReq(who, 1'b0, we, addr, wd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, c0, c1;
    repeat (2) @(negedge clk);
    chk("rst_ack0", 32'(ack0), 32'(0));
    chk("rst_ack1", 32'(ack1), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_mem_re", 32'(mem_re), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_mem_addr", mem_addr, 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_rdata0", 32'(rdata0), 32'(0));
    chk("rst_rdata1", 32'(rdata1), 32'(0));
    chk("rst_owner", 32'(owner), 32'(1));
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous held requests: CPU, DMA, CPU, DMA.
    waitStates = 0;
    push(1'b0, 1'b0, 32'h10, 16'h0, 1, 1'b0, 16'h6EFF);
    push(1'b1, 1'b0, 32'h20, 16'h0, 1, 1'b0, 16'h6ECF);
    push(1'b0, 1'b0, 32'h10, 16'h0, 1, 1'b0, 16'h6EFF);
    push(1'b1, 1'b0, 32'h20, 16'h0, 1, 1'b0, 16'h6ECF);
    fork
      runReq(1'b0, 1'b0, 32'h10, 16'h0, 2, c0);
      runReq(1'b1, 1'b0, 32'h20, 16'h0, 2, c1);
    join
    repeat (2) @(negedge clk);

    // Single zero-wait CPU read.
    push(1'b0, 1'b0, 32'h0000D000, 16'h0, 1, 1'b0, 16'hBEEF);
    runReq(1'b0, 1'b0, 32'h0000D000, 16'h0, 1, cyc);
    chk("cpu_read_latency", 32'(cyc), 32'(2));
    repeat (2) @(negedge clk);

    // DMA write with 3 wait states.
    waitStates = 3;
    push(1'b1, 1'b1, 32'h100, 16'h1234, 4, 1'b0, 16'h0);
    runReq(1'b1, 1'b1, 32'h100, 16'h1234, 1, cyc);
    chk("dma_write_latency", 32'(cyc), 32'(5));
    repeat (2) @(negedge clk);

    // Timeout: ready never arrives.
    stuck = 1'b1;
    push(1'b0, 1'b0, 32'h200, 16'h0, 4, 1'b1, 16'h0);
    runReq(1'b0, 1'b0, 32'h200, 16'h0, 1, cyc);
    chk("timeout_latency", 32'(cyc), 32'(5));
    stuck = 1'b0;
    waitStates = 0;
    repeat (2) @(negedge clk);
    push(1'b0, 1'b0, 32'h400, 16'h0, 1, 1'b0, 16'h6AEF);
    runReq(1'b0, 1'b0, 32'h400, 16'h0, 1, cyc);
    repeat (2) @(negedge clk);

    // Back-to-back CPU reads with one low IDLE cycle in between.
    push(1'b0, 1'b0, 32'h500, 16'h0, 1, 1'b0, 16'h6BEF);
    push(1'b0, 1'b0, 32'h600, 16'h0, 1, 1'b0, 16'h68EF);
    runReq(1'b0, 1'b0, 32'h500, 16'h0, 1, cyc);
    repeat (2) @(negedge clk);
    runReq(1'b0, 1'b0, 32'h600, 16'h0, 1, cyc);
    repeat (2) @(negedge clk);

    // Reset during the second ACCESS cycle, then re-grant of the held request.
    waitStates = 3;
    push(1'b0, 1'b0, 32'h300, 16'h0, 4, 1'b0, 16'h6DEF);
    setReq(1'b0, 1'b1, 1'b0, 32'h300, 16'h0);
    @(negedge clk);
    chk("pre_rst_mem_re", 32'(mem_re), 32'(1));
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_mem_re", 32'(mem_re), 32'(0));
    chk("mid_rst_ack0", 32'(ack0), 32'(0));
    chk("mid_rst_owner", 32'(owner), 32'(1));
    expQ.delete();
    shadow[0] = 16'h0;
    shadow[1] = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(1'b0, 1'b0, 32'h300, 16'h0, 4, 1'b0, 16'h6DEF);
    waitAck(1'b0, cyc);
    setReq(1'b0, 1'b0, 1'b0, 32'h300, 16'h0);
    chk("regrant_latency", 32'(cyc), 32'(5));
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(expQ.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
